// File: rtl/key_schedule_iter.sv
// Iterative AES-128 key expansion: one round key per clock into an 11-slot
// schedule, presented as a flat 1408-bit vector with round 0 in the MSB slice.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  // Entry 0 sits in the top byte of the table
  assign y = SBOX[11'd2047 - {a, 3'b000} -: 8];
endmodule

module key_schedule_iter (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [127:0]  key,
  output logic [1407:0] all_keys,
  output logic          busy,
  output logic          key_valid
);
  localparam int NSLOT = 11;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EXPAND = 2'd1;
  localparam logic [1:0] READY  = 2'd2;

  logic [1:0]   state;
  logic [3:0]   round_cnt;
  logic [7:0]   rcon;
  logic [127:0] slot [NSLOT];
  logic [3:0]   prev_idx;
  logic [127:0] prev;
  logic [31:0]  rot, sub;
  logic [31:0]  w0, w1, w2, w3;
  logic [127:0] nxt;

  // Clamp keeps the read in range when the counter is outside 1..10
  assign prev_idx = (round_cnt == 4'd0 || round_cnt > 4'd10) ? 4'd0 : round_cnt - 4'd1;
  assign prev     = slot[prev_idx];
  assign rot      = {prev[23:0], prev[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sub
    aes_sbox u_sbox (.a(rot[g*8 +: 8]), .y(sub[g*8 +: 8]));
  end

  assign w0  = prev[127:96] ^ sub ^ {rcon, 24'h0};
  assign w1  = prev[95:64] ^ w0;
  assign w2  = prev[63:32] ^ w1;
  assign w3  = prev[31:0]  ^ w2;
  assign nxt = {w0, w1, w2, w3};

  for (genvar g = 0; g < NSLOT; g++) begin : g_out
    assign all_keys[1407-128*g -: 128] = slot[g];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      round_cnt <= 4'd0;
      rcon      <= 8'h01;
      busy      <= 1'b0;
      key_valid <= 1'b0;
      for (int i = 0; i < NSLOT; i++) slot[i] <= '0;
    end else begin
      case (state)
        IDLE, READY: begin
          if (start) begin
            slot[0] <= key;
            for (int i = 1; i < NSLOT; i++) slot[i] <= '0;
            round_cnt <= 4'd1;
            rcon      <= 8'h01;
            busy      <= 1'b1;
            key_valid <= 1'b0;
            state     <= EXPAND;
          end
        end
        EXPAND: begin
          if (round_cnt == 4'd0 || round_cnt > 4'd10) begin
            state     <= IDLE;
            round_cnt <= 4'd0;
            busy      <= 1'b0;
            key_valid <= 1'b0;
          end else begin
            for (int i = 1; i < NSLOT; i++)
              if (round_cnt == 4'(i)) slot[i] <= nxt;
            rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            if (round_cnt == 4'd10) begin
              state     <= READY;
              busy      <= 1'b0;
              key_valid <= 1'b1;
            end else begin
              round_cnt <= round_cnt + 4'd1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          round_cnt <= 4'd0;
          busy      <= 1'b0;
          key_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_key_schedule_iter.sv
// Randomized scoreboard bench for key_schedule_iter against a FIPS-197 model
// whose S-box is derived from GF(2^8) inversion plus the affine map.

module tb_key_schedule_iter;
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [127:0]  key = '0;
  logic [1407:0] all_keys;
  logic          busy, key_valid;

  key_schedule_iter dut (
    .clk(clk), .reset(reset), .start(start), .key(key),
    .all_keys(all_keys), .busy(busy), .key_valid(key_valid)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, mcnt = 0;
  logic [1407:0] exp_q [$];
  int            acc_q [$];
  logic [7:0]    sb [256];

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00, x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [1407:0] expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    logic [1407:0] r;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) r[1407-32*i -: 32] = w[i];
    return r;
  endfunction

  task automatic check_vec(input string name, input logic [1407:0] act, input logic [1407:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rkey();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock; the acceptance rule is "idle or ready", i.e. no expansion pending
  task automatic step(input logic s, input logic [127:0] k);
    start = s;
    key   = k;
    @(posedge clk);
    cyc++;
    if (reset) begin
      if (mcnt == 0 && s) begin
        exp_q.push_back(expand(k));
        acc_q.push_back(cyc);
        mcnt = 10;
      end else if (mcnt > 0) begin
        mcnt--;
      end
    end
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!key_valid && n < 20) begin
      step(1'b0, rkey());
      n++;
    end
    checks++;
    if (!key_valid) begin
      errors++;
      $display("FAIL %s timeout: key_valid=%0b want 1", name, key_valid);
    end
  endtask

  logic prev_kv = 1'b0, prev_busy = 1'b0;
  int   bcnt = 0;

  always @(negedge clk) begin
    logic [1407:0] e;
    int a;
    if (!reset) begin
      prev_kv = 1'b0; prev_busy = 1'b0; bcnt = 0;
    end else begin
      if (busy) bcnt++;
      if (!busy && prev_busy) begin
        check_int("busy_len", bcnt, 10);
        bcnt = 0;
      end
      if (key_valid && !prev_kv) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid: got key_valid=1 want no pending schedule");
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check_vec("schedule", all_keys, e);
          check_int("latency", cyc - a, 10);
          check_int("busy_at_valid", int'(busy), 0);
        end
      end
      prev_kv = key_valid;
      prev_busy = busy;
    end
  end

  initial begin
    build_sbox();
    #12;
    check_int("rst_busy", int'(busy), 0);
    check_int("rst_valid", int'(key_valid), 0);
    check_vec("rst_keys", all_keys, '0);
    #1 reset = 1'b1;

    // Start on the first edge after release, FIPS-197 appendix vector
    step(1'b1, K1);
    wait_valid("k1");
    check_vec("k1_slot0", 1408'(all_keys[1407 -: 128]), 1408'(K1));
    check_vec("k1_slot1", 1408'(all_keys[1279 -: 128]), 1408'(128'hd6aa74fdd2af72fadaa678f1d6ab76fe));
    check_vec("k1_slot10", 1408'(all_keys[127 -: 128]), 1408'(128'h13111d7fe3944a17f307a78b4d2b30c5));

    // Second start with a different key four edges in must be ignored
    step(1'b1, K2);
    repeat (3) step(1'b0, rkey());
    step(1'b1, rkey());
    wait_valid("k2");
    check_vec("k2_slot1", 1408'(all_keys[1279 -: 128]), 1408'(128'ha0fafe1788542cb123a339392a6c7605));
    check_vec("k2_slot10", 1408'(all_keys[127 -: 128]), 1408'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));

    // Asynchronous abort mid-expansion
    step(1'b1, K1);
    repeat (5) step(1'b0, K1);
    #2 reset = 1'b0;
    #1;
    check_int("abort_busy", int'(busy), 0);
    check_int("abort_valid", int'(key_valid), 0);
    check_vec("abort_keys", all_keys, '0);
    exp_q.delete(); acc_q.delete(); mcnt = 0;
    step(1'b0, rkey());
    step(1'b1, rkey());
    #2 reset = 1'b1;
    step(1'b1, K2);
    wait_valid("post_abort");
    check_vec("post_abort_slot10", 1408'(all_keys[127 -: 128]), 1408'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));

    // Restart from READY with an all-zero key
    step(1'b1, '0);
    check_int("restart_valid", int'(key_valid), 0);
    check_vec("restart_clear", all_keys, '0);
    wait_valid("zero");
    check_vec("zero_slot10", 1408'(all_keys[127 -: 128]), 1408'(128'hb4ef5bcb3e92e21123e951cf6f8f188e));

    // Held start re-triggers only from READY
    repeat (35) step(1'b1, rkey());

    repeat (400) step($urandom_range(0, 3) == 0, rkey());
    repeat (15) step(1'b0, rkey());
    check_int("drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
